eu_batch_scheduler: RTL

Sequences a vector of Q10.22 exponent arguments s(x) through a small pool of exponential-unit lanes. Each lane pairs one EU instance with one SharedLUT port, and the block time-multiplexes the lanes across the vector. It accepts one VEC_LEN-element vector per valid/ready handshake and returns the VEC_LEN Q48.16 results of 2^s(x) as one vector. It sits between the GELU/softmax polynomial stage and the downstream normaliser. It replaces a full VEC_LEN-wide EU array with NUM_LANES lanes plus a pass counter.

---
 rtl/eu_sched_pkg.sv | 46 ++++
 rtl/eu_lane_array.sv | 92 +++++++++
 rtl/eu_batch_scheduler.sv | 133 +++++++++++++
 3 files changed

// File: rtl/eu_sched_pkg.sv
// Shared types and constants for the EU batch scheduler: FSM states, clamp
// bounds and the constant functions that size the pass loop and build the LUT.
package eu_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_e;

  // Q10.22 clamp window: -16.0 .. +46.0
  localparam logic signed [31:0] S_MIN = 32'shFC00_0000;
  localparam logic signed [31:0] S_MAX = 32'sh0B80_0000;

  localparam int LUT_BITS = 4;

  function automatic int num_passes(input int vec_len, input int num_lanes);
    return vec_len / num_lanes;
  endfunction

  function automatic logic [63:0] isqrt64(input logic [63:0] x);
    logic [63:0] res;
    logic [63:0] t;
    res = '0;
    for (int b = 31; b >= 0; b--) begin
      t = res | (64'd1 << b);
      if (t * t <= x) res = t;
    end
    return res;
  endfunction

  // 2^(k/2^LUT_BITS) with fb fractional bits, built from chained square roots of 2
  function automatic logic [63:0] exp2_frac(input int k, input int fb);
    logic [63:0] acc;
    logic [63:0] r;
    acc = 64'd1 << fb;
    r   = 64'd2 << fb;
    if (k >= (1 << LUT_BITS)) return 64'd2 << fb;
    for (int b = 1; b <= LUT_BITS; b++) begin
      r = isqrt64(r << fb);
      if (((k >> (LUT_BITS - b)) & 1) != 0) acc = (acc * r) >> fb;
    end
    return acc;
  endfunction

endpackage

// File: rtl/eu_lane_array.sv
// Combinational pool of exponential lanes: NUM_LANES eu_lane instances sharing
// one multi-port 2^frac coefficient table (shared_lut).
module shared_lut
  import eu_sched_pkg::*;
#(
  parameter int NUM_PORTS = 8,
  parameter int WIDTH     = 32
) (
  input  logic [NUM_PORTS-1:0][LUT_BITS-1:0] i_idx,
  output logic [NUM_PORTS-1:0][WIDTH-1:0]    o_c0,
  output logic [NUM_PORTS-1:0][WIDTH-1:0]    o_c1
);
  localparam int ENTRIES = 1 << LUT_BITS;

  logic [WIDTH-1:0] w_tab [0:ENTRIES];

  for (genvar k = 0; k <= ENTRIES; k++) begin : g_tab
    localparam logic [63:0] V = exp2_frac(k, WIDTH - 2);
    assign w_tab[k] = V[WIDTH-1:0];
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    logic [LUT_BITS:0] w_lo, w_hi;
    assign w_lo      = {1'b0, i_idx[p]};
    assign w_hi      = w_lo + 1'b1;
    assign o_c0[p]   = w_tab[w_lo];
    assign o_c1[p]   = w_tab[w_hi] - w_tab[w_lo];
  end
endmodule

module eu_lane
  import eu_sched_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int Q_IN  = 22,
  parameter int Q_OUT = 16
) (
  input  logic [WIDTH-1:0]   i_sx,
  input  logic [WIDTH-1:0]   i_c0,
  input  logic [WIDTH-1:0]   i_c1,
  output logic [LUT_BITS-1:0] o_idx,
  output logic [2*WIDTH-1:0] o_res
);
  localparam int FLO_W   = Q_IN - LUT_BITS;
  localparam int MANT_FB = WIDTH - 2;
  localparam logic signed [WIDTH-1:0] SH0 = WIDTH'(MANT_FB - Q_OUT);

  logic signed [WIDTH-1:0] w_n;
  logic [FLO_W-1:0]        w_flo;
  logic [2*WIDTH-1:0]      w_prod, w_mant;
  logic [WIDTH-1:0]        w_sh;
  logic                    w_left;

  assign w_n    = signed'(i_sx) >>> Q_IN;
  assign o_idx  = i_sx[Q_IN-1 -: LUT_BITS];
  assign w_flo  = i_sx[FLO_W-1:0];
  // Linear interpolation between adjacent table entries, mantissa in Q2.(WIDTH-2)
  assign w_prod = (2*WIDTH)'(i_c1) * (2*WIDTH)'(w_flo);
  assign w_mant = (2*WIDTH)'(i_c0) + (w_prod >> FLO_W);
  assign w_left = (w_n >= SH0);
  assign w_sh   = w_left ? unsigned'(w_n - SH0) : unsigned'(SH0 - w_n);
  assign o_res  = w_left ? (w_mant << w_sh) : (w_mant >> w_sh);
endmodule

module eu_lane_array
  import eu_sched_pkg::*;
#(
  parameter int NUM_LANES = 8,
  parameter int WIDTH     = 32,
  parameter int Q_IN      = 22,
  parameter int Q_OUT     = 16
) (
  input  logic [NUM_LANES-1:0][WIDTH-1:0]   lane_sx,
  output logic [NUM_LANES-1:0][2*WIDTH-1:0] lane_res
);
  logic [NUM_LANES-1:0][LUT_BITS-1:0] w_idx;
  logic [NUM_LANES-1:0][WIDTH-1:0]    w_c0, w_c1;

  shared_lut #(.NUM_PORTS(NUM_LANES), .WIDTH(WIDTH)) u_lut (
    .i_idx (w_idx),
    .o_c0  (w_c0),
    .o_c1  (w_c1)
  );

  eu_lane #(.WIDTH(WIDTH), .Q_IN(Q_IN), .Q_OUT(Q_OUT)) u_lane [NUM_LANES-1:0] (
    .i_sx  (lane_sx),
    .i_c0  (w_c0),
    .i_c1  (w_c1),
    .o_idx (w_idx),
    .o_res (lane_res)
  );
endmodule

// File: rtl/eu_batch_scheduler.sv
// Time-multiplexes a VEC_LEN vector of Q10.22 exponents through NUM_LANES EU lanes.
// Optional input clamp to [-16.0, +46.0] with per-element flag: EU_SCHED_CLAMP_EN.
module eu_batch_scheduler
  import eu_sched_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int Q_IN      = 22,
  parameter int Q_OUT     = 16,
  parameter int VEC_LEN   = 32,
  parameter int NUM_LANES = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [VEC_LEN-1:0][WIDTH-1:0]     in_vec,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [VEC_LEN-1:0][2*WIDTH-1:0]   out_vec,
  output logic [VEC_LEN-1:0]                out_sat,
  output logic                              busy
);
  localparam int NUM_PASSES = num_passes(VEC_LEN, NUM_LANES);
  localparam int PW         = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
  localparam logic [PW-1:0] LAST_PASS = PW'(NUM_PASSES - 1);

  if (VEC_LEN % NUM_LANES != 0) begin : g_cfg_err
    $error("eu_batch_scheduler: VEC_LEN must be a multiple of NUM_LANES");
  end

  sched_state_e r_state, w_state_nxt;
  logic [PW-1:0] r_pass;
  // Buffers viewed as [pass][lane] so the slice mux is a plain index by r_pass
  logic [NUM_PASSES-1:0][NUM_LANES-1:0][WIDTH-1:0]   r_in_buf;
  logic [NUM_PASSES-1:0][NUM_LANES-1:0][2*WIDTH-1:0] r_out_buf;

  logic w_in_ready, w_out_valid, w_accept, w_last;
  logic [NUM_LANES-1:0][WIDTH-1:0]   w_lane_raw, w_lane_sx;
  logic [NUM_LANES-1:0][2*WIDTH-1:0] w_lane_res;

  assign w_lane_raw = r_in_buf[r_pass];
  assign w_last     = (r_pass == LAST_PASS);

  always_comb begin
    w_state_nxt = r_state;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) w_state_nxt = RUN;
      end
      RUN: begin
        if (w_last) w_state_nxt = DONE;
      end
      DONE: begin
        w_out_valid = 1'b1;
        w_in_ready  = out_ready;
        if (out_ready) w_state_nxt = in_valid ? RUN : IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    w_accept = in_valid && w_in_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_pass   <= '0;
      r_in_buf <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_pass   <= '0;
        r_in_buf <= in_vec;
      end else if (r_state == RUN) begin
        r_pass <= w_last ? '0 : r_pass + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_out_buf <= '0;
    else if (r_state == RUN) r_out_buf[r_pass] <= w_lane_res;
  end

`ifdef EU_SCHED_CLAMP_EN
  localparam logic signed [WIDTH-1:0] C_LO = WIDTH'(S_MIN);
  localparam logic signed [WIDTH-1:0] C_HI = WIDTH'(S_MAX);

  logic [NUM_LANES-1:0]                   w_clip;
  logic [NUM_PASSES-1:0][NUM_LANES-1:0]   r_out_sat;

  always_comb begin
    w_lane_sx = w_lane_raw;
    w_clip    = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (signed'(w_lane_raw[l]) > C_HI) begin
        w_lane_sx[l] = C_HI;
        w_clip[l]    = 1'b1;
      end else if (signed'(w_lane_raw[l]) < C_LO) begin
        w_lane_sx[l] = C_LO;
        w_clip[l]    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_out_sat <= '0;
    else if (r_state == RUN) r_out_sat[r_pass] <= w_clip;
  end

  assign out_sat = r_out_sat;
`else
  assign w_lane_sx = w_lane_raw;
  assign out_sat   = '0;
`endif

  eu_lane_array #(
    .NUM_LANES (NUM_LANES),
    .WIDTH     (WIDTH),
    .Q_IN      (Q_IN),
    .Q_OUT     (Q_OUT)
  ) u_lanes (
    .lane_sx  (w_lane_sx),
    .lane_res (w_lane_res)
  );

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_vec   = r_out_buf;
  assign busy      = (r_state != IDLE);
endmodule
